// File: rtl/icache_way_array_if.sv
// Lookup/response and refill-write bundle between the ICache control FSM
// (master) and the way array (slave).
interface icache_way_array_if #(
  parameter int WAYS       = 2,
  parameter int INDEX_W    = 7,
  parameter int TAG_W      = 20,
  parameter int LINE_WORDS = 8
);
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  // lookup request
  logic               rd_en;
  logic [INDEX_W-1:0] rd_index;
  logic [TAG_W-1:0]   rd_tag;
  // lookup response, one cycle later
  logic               rsp_valid;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [LINE_W-1:0]  rsp_data;
  logic [WAY_W-1:0]   victim_way;
  // refill write
  logic               wr_en;
  logic [INDEX_W-1:0] wr_index;
  logic [WAY_W-1:0]   wr_way;
  logic [TAG_W-1:0]   wr_tag;
  logic [LINE_W-1:0]  wr_data;
  logic               wr_valid;

  modport master (
    output rd_en, rd_index, rd_tag,
    output wr_en, wr_index, wr_way, wr_tag, wr_data, wr_valid,
    input  rsp_valid, hit, hit_way, rsp_data, victim_way
  );

  modport slave (
    input  rd_en, rd_index, rd_tag,
    input  wr_en, wr_index, wr_way, wr_tag, wr_data, wr_valid,
    output rsp_valid, hit, hit_way, rsp_data, victim_way
  );
endinterface

// File: rtl/icache_way_array.sv
// N-way set-associative ICache storage: per-way tag/data/valid RAMs, per-set
// tree pseudo-LRU, tag compare and victim choice one cycle after a lookup,
// plus a counter-driven sweep that invalidates every set.
module icache_way_array #(
  parameter int WAYS       = 2,
  parameter int INDEX_W    = 7,
  parameter int TAG_W      = 20,
  parameter int LINE_WORDS = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic inv_all,
  output logic busy,
  icache_way_array_if.slave bus
);
  localparam int SETS   = 1 << INDEX_W;
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

  // Tree PLRU bits are a heap: node n (root = 1) lives at bit n-1, its
  // children are 2n and 2n+1, and leaves WAYS..2*WAYS-1 are the ways.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] res;
    logic [PLRU_W-1:0] mask;
    int node;
    int parent;
    res = bits;
    if (WAYS > 1) begin
      node = WAYS + int'(way);
      for (int l = 0; l < WAY_W; l++) begin
        parent = node >> 1;
        mask   = PLRU_W'(1) << (parent - 1);
        // left (even) child: point the parent right, and vice versa
        res    = node[0] ? (res & ~mask) : (res | mask);
        node   = parent;
      end
    end
    return res;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [PLRU_W-1:0] tmp;
    int node;
    node = 1;
    if (WAYS > 1) begin
      for (int l = 0; l < WAY_W; l++) begin
        tmp  = bits >> (node - 1);
        node = 2 * node + (tmp[0] ? 1 : 0);
      end
      return WAY_W'(node - WAYS);
    end
    return '0;
  endfunction

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               live_q, live_d;     // registered set state belongs to a real lookup
  logic [INDEX_W-1:0] rd_index_q, rd_index_d;
  logic [TAG_W-1:0]   rd_tag_q, rd_tag_d;

  logic               rd_acc;
  logic               wr_acc;
  logic               out_en;
  logic               hit_upd;
  logic               hit_any;
  logic [WAY_W-1:0]   hit_idx;
  logic               inv_any;
  logic [WAY_W-1:0]   inv_idx;
  logic [WAY_W-1:0]   victim_sel;
  logic [LINE_W-1:0]  data_sel;

  logic [TAG_W-1:0]   tag_rd   [WAYS];
  logic [LINE_W-1:0]  data_rd  [WAYS];
  logic               valid_rd [WAYS];
  logic [PLRU_W-1:0]  plru_mem [SETS];
  logic [PLRU_W-1:0]  plru_rd_q;

  assign busy   = (state_q == S_SWEEP);
  // traffic is dropped while sweeping and while reset is held
  assign rd_acc = bus.rd_en & ~busy & resetn;
  assign wr_acc = bus.wr_en & ~busy & resetn;

  // Sweep FSM: next state and invalidate counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (inv_all) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        if (inv_all) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sweep FSM registers; reset starts a fresh sweep from set 0
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lookup pipeline next-state: response valid and the captured request
  always_comb begin
    rsp_valid_d = rd_acc;
    live_d      = live_q;
    rd_index_d  = rd_index_q;
    rd_tag_d    = rd_tag_q;
    if (busy) begin
      live_d = 1'b0;
    end else if (rd_acc) begin
      live_d     = 1'b1;
      rd_index_d = bus.rd_index;
      rd_tag_d   = bus.rd_tag;
    end
  end

  // Lookup pipeline registers; reset discards any in-flight response
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_valid_q <= 1'b0;
      live_q      <= 1'b0;
      rd_index_q  <= '0;
      rd_tag_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      live_q      <= live_d;
      rd_index_q  <= rd_index_d;
      rd_tag_q    <= rd_tag_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]  tag_mem   [SETS];
      logic [LINE_W-1:0] data_mem  [SETS];
      logic              valid_mem [SETS];
      logic [TAG_W-1:0]  tag_rd_q;
      logic [LINE_W-1:0] data_rd_q;
      logic              valid_rd_q;
      logic              wr_sel;

      assign wr_sel       = wr_acc && (bus.wr_way == WAY_W'(gi));
      assign tag_rd[gi]   = tag_rd_q;
      assign data_rd[gi]  = data_rd_q;
      assign valid_rd[gi] = valid_rd_q;

      // Tag/data RAM: refill write, read-first registered read
      always_ff @(posedge clk) begin
        if (wr_sel) begin
          tag_mem[bus.wr_index]  <= bus.wr_tag;
          data_mem[bus.wr_index] <= bus.wr_data;
        end
        if (rd_acc) begin
          tag_rd_q  <= tag_mem[bus.rd_index];
          data_rd_q <= data_mem[bus.rd_index];
        end
      end

      // Valid bits: cleared by the sweep, else set/cleared by refill writes
      always_ff @(posedge clk) begin
        if (busy) begin
          valid_mem[cnt_q] <= 1'b0;
        end else if (wr_sel) begin
          valid_mem[bus.wr_index] <= bus.wr_valid;
        end
        if (rd_acc) begin
          valid_rd_q <= valid_mem[bus.rd_index];
        end
      end
    end
  endgenerate

  // PLRU state: sweep clear, else hit and write updates (write last, so it wins)
  always_ff @(posedge clk) begin
    if (busy) begin
      plru_mem[cnt_q] <= '0;
    end else begin
      if (hit_upd) begin
        plru_mem[rd_index_q] <= plru_touch(plru_mem[rd_index_q], hit_idx);
      end
      if (wr_acc) begin
        plru_mem[bus.wr_index] <= plru_touch(plru_mem[bus.wr_index], bus.wr_way);
      end
    end
    if (rd_acc) begin
      plru_rd_q <= plru_mem[bus.rd_index];
    end
  end

  // Tag compare, lowest hit way, lowest invalid way and victim choice
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_rd[w] && (tag_rd[w] == rd_tag_q)) begin
        hit_any = 1'b1;
        hit_idx = WAY_W'(w);
      end
      if (!valid_rd[w]) begin
        inv_any = 1'b1;
        inv_idx = WAY_W'(w);
      end
    end
    victim_sel = inv_any ? inv_idx : plru_victim(plru_rd_q);
    data_sel   = hit_any ? data_rd[hit_idx] : '0;
  end

  // outputs hold between lookups but read as zero after reset and while sweeping
  assign out_en         = live_q & ~busy;
  assign hit_upd        = rsp_valid_q & out_en & hit_any;
  assign bus.rsp_valid  = rsp_valid_q & ~busy;
  assign bus.hit        = out_en & hit_any;
  assign bus.hit_way    = out_en ? hit_idx : '0;
  assign bus.rsp_data   = out_en ? data_sel : '0;
  assign bus.victim_way = out_en ? victim_sel : '0;
endmodule

// File: tb/tb_icache_way_array.sv
// Directed bench for icache_way_array (4 ways, 128 sets): expected responses
// are queued when a lookup is issued and checked when rsp_valid appears.
module tb_icache_way_array;
  localparam int WAYS       = 4;
  localparam int INDEX_W    = 7;
  localparam int TAG_W      = 20;
  localparam int LINE_WORDS = 8;
  localparam int LINE_W     = 256;

  typedef struct {
    int               id;
    int               due;
    logic             hit;
    logic [1:0]       way;
    logic [LINE_W-1:0] data;
    logic [1:0]       victim;
  } exp_t;

  logic clk;
  logic resetn;
  logic inv_all;
  logic busy;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   n_lk   = 0;
  exp_t sb_q[$];

  icache_way_array_if #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W),
                        .LINE_WORDS(LINE_WORDS)) bus ();

  icache_way_array #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W),
                     .LINE_WORDS(LINE_WORDS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .inv_all(inv_all),
    .busy   (busy),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] seed);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_WORDS; i++) l[i*32 +: 32] = seed + 32'(i) * 32'h0100_0193;
    return l;
  endfunction

  task automatic step();
    @(negedge clk);
    bus.rd_en  = 1'b0;
    bus.wr_en  = 1'b0;
    inv_all    = 1'b0;
  endtask

  task automatic lookup(input int idx, input logic [TAG_W-1:0] tag, input logic h,
                        input logic [1:0] w, input logic [LINE_W-1:0] d,
                        input logic [1:0] v);
    bus.rd_en    = 1'b1;
    bus.rd_index = INDEX_W'(idx);
    bus.rd_tag   = tag;
    sb_q.push_back('{n_lk, cyc + 1, h, w, d, v});
    $display("issue lk%0d set=%0d tag=%h exp hit=%0d way=%0d victim=%0d",
             n_lk, idx, tag, h, w, v);
    n_lk++;
  endtask

  task automatic write(input int idx, input int way, input logic [TAG_W-1:0] tag,
                       input logic [LINE_W-1:0] d, input logic vld);
    bus.wr_en    = 1'b1;
    bus.wr_index = INDEX_W'(idx);
    bus.wr_way   = 2'(way);
    bus.wr_tag   = tag;
    bus.wr_data  = d;
    bus.wr_valid = vld;
    $display("write set=%0d way=%0d tag=%h valid=%0d", idx, way, tag, vld);
  endtask

  // Response scoreboard: every rsp_valid must match the oldest queued lookup
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid === 1'b1) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_rsp observed=rsp_valid expected=no_response");
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk($sformatf("lk%0d_cycle", e.id), LINE_W'(cyc), LINE_W'(e.due));
        chk($sformatf("lk%0d_hit", e.id), LINE_W'(bus.hit), LINE_W'(e.hit));
        chk($sformatf("lk%0d_hit_way", e.id), LINE_W'(bus.hit_way), LINE_W'(e.way));
        chk($sformatf("lk%0d_data", e.id), bus.rsp_data, e.data);
        chk($sformatf("lk%0d_victim", e.id), LINE_W'(bus.victim_way), LINE_W'(e.victim));
        $display("resp lk%0d hit=%0d way=%0d victim=%0d", e.id, bus.hit,
                 bus.hit_way, bus.victim_way);
      end
    end
  end

  initial begin
    int n;
    resetn       = 1'b0;
    inv_all      = 1'b0;
    bus.rd_en    = 1'b0;
    bus.rd_index = '0;
    bus.rd_tag   = '0;
    bus.wr_en    = 1'b0;
    bus.wr_index = '0;
    bus.wr_way   = '0;
    bus.wr_tag   = '0;
    bus.wr_data  = '0;
    bus.wr_valid = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy", LINE_W'(busy), LINE_W'(1'b1));
    chk("rst_rsp_valid", LINE_W'(bus.rsp_valid), LINE_W'(1'b0));
    chk("rst_hit", LINE_W'(bus.hit), LINE_W'(1'b0));
    chk("rst_hit_way", LINE_W'(bus.hit_way), LINE_W'(2'd0));
    chk("rst_rsp_data", bus.rsp_data, '0);
    chk("rst_victim", LINE_W'(bus.victim_way), LINE_W'(2'd0));

    // sweep length after reset, with a lookup issued while busy
    resetn = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      if (n == 10) begin
        bus.rd_en    = 1'b1;
        bus.rd_index = 7'd4;
        bus.rd_tag   = 20'h0;
      end
      step();
      if (n == 10) chk("busy_lookup_dropped", LINE_W'(bus.rsp_valid), LINE_W'(1'b0));
      n++;
    end
    chk("sweep_len", LINE_W'(n), LINE_W'(128));

    // empty array misses everywhere
    lookup(0, 20'h00000, 1'b0, 2'd0, '0, 2'd0);   step();
    lookup(77, 20'h0abcd, 1'b0, 2'd0, '0, 2'd0);  step();
    lookup(127, 20'hfffff, 1'b0, 2'd0, '0, 2'd0); step();
    step();

    // refill then hit
    write(5, 1, 20'h12345, mk_line(32'h5000_0051), 1'b1); step();
    lookup(5, 20'h12345, 1'b1, 2'd1, mk_line(32'h5000_0051), 2'd0); step();
    lookup(5, 20'h12346, 1'b0, 2'd0, '0, 2'd0); step();
    step();

    // PLRU on a full set
    for (int w = 0; w < 4; w++) begin
      write(3, w, 20'h00300 + 20'(w), mk_line(32'h3000_0000 + 32'(w)), 1'b1);
      step();
    end
    lookup(3, 20'h00300, 1'b1, 2'd0, mk_line(32'h3000_0000), 2'd0); step(); step();
    lookup(3, 20'h00302, 1'b1, 2'd2, mk_line(32'h3000_0002), 2'd2); step(); step();
    lookup(3, 20'h00999, 1'b0, 2'd0, '0, 2'd1); step(); step();

    // read/write collision is read-first
    write(9, 0, 20'habcde, mk_line(32'h9000_0009), 1'b1);
    lookup(9, 20'habcde, 1'b0, 2'd0, '0, 2'd0); step();
    lookup(9, 20'habcde, 1'b1, 2'd0, mk_line(32'h9000_0009), 2'd1); step();
    step();

    // single-line invalidate
    write(3, 2, 20'h00302, mk_line(32'h0), 1'b0); step();
    lookup(3, 20'h00302, 1'b0, 2'd0, '0, 2'd2); step();
    lookup(3, 20'h00301, 1'b1, 2'd1, mk_line(32'h3000_0001), 2'd2); step();
    step();

    // dropped traffic during an inv_all sweep
    write(0, 0, 20'h00100, mk_line(32'h0100_0000), 1'b1); step();
    write(1, 0, 20'h00101, mk_line(32'h0100_0001), 1'b1); step();
    write(2, 0, 20'h00102, mk_line(32'h0100_0002), 1'b1); step();
    lookup(1, 20'h00101, 1'b1, 2'd0, mk_line(32'h0100_0001), 2'd1); step();
    step();
    inv_all = 1'b1;
    step();
    chk("inv_busy", LINE_W'(busy), LINE_W'(1'b1));
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      if (n == 40) begin
        write(1, 1, 20'h00777, mk_line(32'h7777_0000), 1'b1);
        bus.rd_en    = 1'b1;
        bus.rd_index = 7'd1;
        bus.rd_tag   = 20'h00101;
      end
      step();
      n++;
    end
    chk("sweep2_len", LINE_W'(n), LINE_W'(128));
    lookup(0, 20'h00100, 1'b0, 2'd0, '0, 2'd0); step();
    lookup(1, 20'h00101, 1'b0, 2'd0, '0, 2'd0); step();
    lookup(1, 20'h00777, 1'b0, 2'd0, '0, 2'd0); step();
    lookup(2, 20'h00102, 1'b0, 2'd0, '0, 2'd0); step();
    lookup(3, 20'h00300, 1'b0, 2'd0, '0, 2'd0); step();
    step();
    step();

    chk("sb_drained", LINE_W'(sb_q.size()), LINE_W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/icache_way_array.md
# icache_way_array

Parametrised N-way set-associative storage array for the instruction cache: per-way tag and data RAM, per-set valid bits and tree pseudo-LRU state. The array performs the tag compare itself and returns hit, hit way, hit line and refill victim one cycle after a lookup. It accepts one refill write per cycle from the ICache refill FSM. A counter-driven sweep invalidates all sets after reset or on request. It sits between the ICache control FSM and the AXI refill path and generalises the single-way array.

## Interface
- WAYS, 2: associativity; power of two, 1..8.
- INDEX_W, 7: set index width; SETS = 2**INDEX_W.
- TAG_W, 20: tag width.
- LINE_WORDS, 8: 32-bit words per line; LINE_W = 32*LINE_WORDS.
- WAY_W, derived: max(1, clog2(WAYS)).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- inv_all  in  1  pulse; starts a full invalidate sweep.
- busy  out  1  sweep in progress; lookups and writes are ignored while high.
- rd_en  in  1  lookup request.
- rd_index  in  INDEX_W  lookup set.
- rd_tag  in  TAG_W  tag to compare.
- rsp_valid  out  1  response valid; equals rd_en delayed 1 cycle, gated by busy.
- hit  out  1  some valid way matched rd_tag.
- hit_way  out  WAY_W  lowest-numbered matching way.
- rsp_data  out  LINE_W  line of hit_way; all-zero when there is no hit.
- victim_way  out  WAY_W  refill target for the looked-up set.
- wr_en  in  1  refill write.
- wr_index  in  INDEX_W  write set.
- wr_way  in  WAY_W  write way.
- wr_tag  in  TAG_W  tag to store.
- wr_data  in  LINE_W  line to store.
- wr_valid  in  1  valid bit to store; 0 invalidates a single line.

## Operation
- Lookup accepted in cycle T:
  - The tag, valid and PLRU state for rd_index are read at the edge ending T.
  - The data RAM is synchronous-read.
  - In cycle T+1: rsp_valid=1; hit is the OR over ways of (valid & tag==rd_tag); hit_way, rsp_data and victim_way are combinational from the registered set state.
- Victim selection:
  - The lowest-numbered invalid way, if any way is invalid.
  - Otherwise the tree-PLRU way: walk from the root and follow each bit (0 = left/lower half, 1 = right); WAYS-1 bits per set.
  - WAYS=1 means victim_way=0.
- PLRU update:
  - On a hit in T+1, the hit way's path bits are set to point away from it. This commits at the edge ending T+1.
  - On wr_en, the written way is updated the same way. This commits at the edge ending the write cycle.
  - If both updates target the same set at the same edge, the write update wins.
- Write: at the edge ending the cycle, tag[wr_way][wr_index], data and valid are written.
- Read/write collision on the same set in the same cycle is read-first: the response reflects pre-write tag, valid, data and PLRU.
- Sweep FSM has two states, IDLE and SWEEP, with counter cnt (INDEX_W bits):
  - SWEEP: each cycle clears valid[all ways][cnt] and PLRU[cnt], then increments cnt. After cnt = SETS-1 it moves to IDLE. Duration is SETS cycles.
  - IDLE→SWEEP on inv_all; cnt is set to 0.
  - inv_all during SWEEP restarts cnt at 0.
  - busy=1 exactly in SWEEP.
  - rd_en and wr_en asserted while busy are dropped: no state change and no response.
- Tag and data contents are never cleared; only valid and PLRU are cleared.

## Timing
- Reset (resetn=0 at an edge):
  - Enters SWEEP with cnt=0.
  - busy=1, rsp_valid=0, hit=0, hit_way=0, rsp_data=0, victim_way=0.
  - Any in-flight response is discarded.
  - The first usable lookup is the cycle after busy falls, which is SETS+1 cycles after the last reset edge.
- Reset mid-sweep restarts the sweep from 0.
- Lookup latency is 1 cycle. Fully pipelined: one lookup per cycle, with any mix of indices.
- A lookup in T+1 to the same set as a hit in T sees pre-update PLRU, because updates commit at the edge ending T+1 (read-first).
- A write in cycle W is visible to lookups issued in W+1 and later.
- Outputs hold their last value when rsp_valid=0, except after reset and during sweep, where they are 0.

## Test plan
- Reset, then sweep timing: release resetn with INDEX_W=7 → busy high for exactly 128 cycles. A lookup issued while busy gets no rsp_valid. A lookup of any set after sweep → hit=0, victim_way=0.
- Refill then hit (WAYS=2):
  - Write set 5, way 1, tag 0x12345, data pattern D.
  - Lookup of set 5, tag 0x12345 in the next cycle → T+1 shows hit=1, hit_way=1, rsp_data=D.
  - Lookup with tag 0x12346 → hit=0, victim_way=0 (way 0 is invalid).
- PLRU (WAYS=4):
  - Fill set 3 with ways 0,1,2,3 in order → victim_way=0.
  - Hit way 0 → victim_way=2.
  - Then hit way 2 → victim_way=1.
- Collision: write set 9, way 0 in the same cycle as a lookup of set 9 with the new tag → hit=0. Repeating the lookup next cycle → hit=1.
- Dropped traffic: pulse inv_all after filling sets 0..3; issue wr_en to set 1 during the sweep → after the sweep, all lookups miss and the dropped write left no valid line.
- Single-line invalidate: write with wr_valid=0 to a hit line → next lookup misses, and victim_way points to that way.
